prog_clock_divider: RTL and testbench
=====================================

PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter N, default 26: counter and terminal-count width in bits.
REQ-002 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-003 Parameter CLK_FREQ, default 100000000: input clock frequency in Hz.
REQ-004 Parameter OUT_FREQ, default 1: reset-time output frequency in Hz; DEF_TC = CLK_FREQ/(2*OUT_FREQ)-1, which SHALL fit in N bits.
REQ-005 CP  input  1: single clock; all logic on its rising edge.
REQ-006 CLR  input  1: reset, asynchronous, active-high.
REQ-007 wr_en  input  1: terminal-count write strobe, one transfer per high cycle.
REQ-008 wr_ch  input  max(1,clog2(NCH)): target channel of the write.
REQ-009 wr_tc  input  N: new terminal count; half-period = wr_tc+1 CP cycles.
REQ-010 en  input  NCH: per-channel run enable, level-sensitive.
REQ-011 clk_out  output  NCH: per-channel divided square wave, registered.
REQ-012 tick  output  NCH: per-channel one-CP-cycle pulse, registered, coincident with each clk_out rising edge.
REQ-013 pend  output  NCH: per-channel flag, high while a written terminal count awaits application.

Function
REQ-014 Each channel SHALL hold active TC, shadow TC, pend flag, counter cnt[N-1:0] and clk_out; channel state is IDLE (en=0) or RUN (en=1).
REQ-015 IDLE: cnt=0, clk_out=0, tick=0; a write to an IDLE channel SHALL load active TC directly the next cycle and leave pend=0.
REQ-016 IDLE->RUN on en=1: counting starts that cycle from cnt=0 with clk_out=0; first clk_out rise after TC+1 cycles.
REQ-017 RUN: if cnt<TC then cnt+1; if cnt==TC (wrap) then cnt=0 and clk_out toggles.
REQ-018 tick SHALL be 1 exactly in the cycle clk_out becomes 1; full period = 2*(TC+1) cycles, 50% duty.
REQ-019 TC=0 SHALL give clk_out = CP/2, with tick high every second cycle.
REQ-020 Write to a RUN channel: shadow=wr_tc and pend=1; at the next wrap active TC=shadow, pend=0; the current half-period is never shortened or stretched.
REQ-021 Write in the same cycle as a wrap SHALL take effect at that wrap (bypass); pend stays 0.
REQ-022 A second write before application SHALL overwrite the shadow; only the last value is applied.
REQ-023 RUN->IDLE on en=0: next cycle cnt=0, clk_out=0, tick=0; any pending shadow is applied and pend cleared.
REQ-024 wr_ch >= NCH SHALL be ignored with no state change.
REQ-025 Channels SHALL be fully independent; concurrent wraps on different channels have no interaction.

Reset
REQ-026 While CLR=1, asynchronously: active TC=DEF_TC, shadow=DEF_TC, pend=0, cnt=0, clk_out=0, tick=0 on all channels.
REQ-027 Reset mid-period SHALL abort the half-period; after CLR falls, each channel resumes per REQ-016 according to its en.

Structure
REQ-028 Shared package prog_div_pkg SHALL hold default N, NCH, CLK_FREQ, OUT_FREQ and the DEF_TC computation.
REQ-029 One sub-module, div_channel (counter, TC/shadow registers, toggle and tick logic), SHALL be instantiated NCH times by a generate loop; the top decodes wr_ch into per-channel write strobes.

Verification
REQ-030 CLR pulse with en=0 -> all clk_out/tick/pend = 0; read-back of active TC = DEF_TC (49_999_999 at defaults).
REQ-031 IDLE write TC=2 to ch0, then en[0]=1 -> clk_out[0] rises 3 cycles after enable, period 6, tick one cycle at each rise.
REQ-032 ch1 running TC=3, write TC=1 mid-half-period -> pend[1]=1 until the wrap, current half stays 4 cycles, following halves 2 cycles.
REQ-033 Write TC=0 in the exact wrap cycle of a TC=4 channel -> next half-period is 1 cycle and pend never asserts.
REQ-034 en[2] dropped mid-period with a pending write -> next cycle clk_out[2]=0 and pend[2]=0; re-enable uses the new TC from cnt=0.
REQ-035 NCH=3 build with wr_ch=3 write -> no channel changes; CLR asserted mid-run -> immediate zero outputs, then restart per REQ-016.

Source files
------------

// File: rtl/prog_div_pkg.sv
// Shared defaults and helpers for the programmable clock divider.
// Holds default width, channel count, clock/output frequencies and the
// reset terminal-count computation used by prog_clock_divider.
package prog_div_pkg;

    localparam int unsigned DEF_N        = 26;
    localparam int unsigned DEF_NCH      = 4;
    localparam int unsigned DEF_CLK_FREQ = 100_000_000;
    localparam int unsigned DEF_OUT_FREQ = 1;

    // Terminal count giving out_freq from clk_freq: half-period = tc+1 cycles.
    function automatic int unsigned calc_def_tc(input int unsigned clk_freq,
                                                input int unsigned out_freq);
        return (clk_freq / (32'd2 * out_freq)) - 32'd1;
    endfunction

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int unsigned ch_width(input int unsigned nch);
        return (nch > 32'd1) ? 32'($clog2(nch)) : 32'd1;
    endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active/shadow terminal count, toggle and tick.
// Ports:
//   CP, CLR       clock, asynchronous active-high reset
//   en            run enable (0 = IDLE, 1 = RUN)
//   wr, wr_tc     terminal-count write strobe and value for this channel
//   clk_out       divided square wave, half-period = tc+1 cycles
//   tick          one-cycle pulse in the cycle clk_out becomes 1
//   pend          a written terminal count is waiting for the next wrap
module div_channel #(
    parameter int unsigned   N      = 26,
    parameter logic [N-1:0]  DEF_TC = '0
) (
    input  logic         CP,
    input  logic         CLR,
    input  logic         en,
    input  logic         wr,
    input  logic [N-1:0] wr_tc,
    output logic         clk_out,
    output logic         tick,
    output logic         pend
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] tc_q;
    logic [N-1:0] shadow_q;
    logic         pend_q;
    logic         clk_q;
    logic         tick_q;

    logic         wrap_c;
    logic [N-1:0] tc_apply_c;

    // >= keeps the counter safe even if tc ever dropped below cnt.
    assign wrap_c = (cnt_q >= tc_q);

    // Value taken by the active TC at a wrap or while idle: a same-cycle
    // write bypasses the shadow, otherwise a pending shadow is applied.
    always_comb begin
        tc_apply_c = tc_q;
        if (wr) begin
            tc_apply_c = wr_tc;
        end else if (pend_q) begin
            tc_apply_c = shadow_q;
        end
    end

    // Channel state: IDLE clears the counter, RUN counts and toggles on wrap.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            cnt_q    <= '0;
            tc_q     <= DEF_TC;
            shadow_q <= DEF_TC;
            pend_q   <= 1'b0;
            clk_q    <= 1'b0;
            tick_q   <= 1'b0;
        end else if (!en) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            pend_q <= 1'b0;
            tc_q   <= tc_apply_c;
            if (wr) begin
                shadow_q <= wr_tc;
            end
        end else if (wrap_c) begin
            cnt_q  <= '0;
            clk_q  <= ~clk_q;
            tick_q <= ~clk_q;
            pend_q <= 1'b0;
            tc_q   <= tc_apply_c;
            if (wr) begin
                shadow_q <= wr_tc;
            end
        end else begin
            cnt_q  <= cnt_q + N'(1);
            tick_q <= 1'b0;
            if (wr) begin
                shadow_q <= wr_tc;
                pend_q   <= 1'b1;
            end
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider.
// Ports:
//   CP, CLR          clock, asynchronous active-high reset
//   wr_en            terminal-count write strobe
//   wr_ch            target channel (values >= NCH are ignored)
//   wr_tc            new terminal count
//   en[NCH]          per-channel run enable
//   clk_out[NCH]     divided square waves
//   tick[NCH]        pulse coincident with each clk_out rising edge
//   pend[NCH]        written terminal count awaiting application
module prog_clock_divider
    import prog_div_pkg::*;
#(
    parameter int unsigned N        = DEF_N,
    parameter int unsigned NCH      = DEF_NCH,
    parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
    parameter int unsigned OUT_FREQ = DEF_OUT_FREQ
) (
    input  logic                       CP,
    input  logic                       CLR,
    input  logic                       wr_en,
    input  logic [ch_width(NCH)-1:0]   wr_ch,
    input  logic [N-1:0]               wr_tc,
    input  logic [NCH-1:0]             en,
    output logic [NCH-1:0]             clk_out,
    output logic [NCH-1:0]             tick,
    output logic [NCH-1:0]             pend
);

    localparam int unsigned CHW    = ch_width(NCH);
    localparam int unsigned DEF_TC = calc_def_tc(CLK_FREQ, OUT_FREQ);

    logic [NCH-1:0] wr_stb;

    // Per-channel write decode and channel instances.
    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        assign wr_stb[i] = wr_en && (wr_ch == CHW'(i));

        div_channel #(
            .N      (N),
            .DEF_TC (N'(DEF_TC))
        ) u_ch (
            .CP      (CP),
            .CLR     (CLR),
            .en      (en[i]),
            .wr      (wr_stb[i]),
            .wr_tc   (wr_tc),
            .clk_out (clk_out[i]),
            .tick    (tick[i]),
            .pend    (pend[i])
        );
    end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider: 3 channels, 8-bit counters,
// CLK_FREQ=12 / OUT_FREQ=1 so the reset terminal count is 5 (6-cycle halves).
module tb_prog_clock_divider;
    import prog_div_pkg::*;

    localparam int unsigned N   = 8;
    localparam int unsigned NCH = 3;

    logic           CP;
    logic           CLR;
    logic           wr_en;
    logic [1:0]     wr_ch;
    logic [N-1:0]   wr_tc;
    logic [NCH-1:0] en;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] pend;

    int vectors;
    int miscompares;
    int n;

    prog_clock_divider #(
        .N        (N),
        .NCH      (NCH),
        .CLK_FREQ (12),
        .OUT_FREQ (1)
    ) dut (
        .CP      (CP),
        .CLR     (CLR),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_tc   (wr_tc),
        .en      (en),
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from the edge.
    task automatic step();
        @(posedge CP);
        #1;
    endtask

    task automatic write(input logic [1:0] ch, input logic [N-1:0] tc);
        wr_en = 1'b1;
        wr_ch = ch;
        wr_tc = tc;
        step();
        wr_en = 1'b0;
    endtask

    // Edges until the next tick on channel ch; 0 on timeout.
    task automatic wait_rise(input logic [1:0] ch, output int cnt);
        int k;
        k   = 0;
        cnt = 0;
        while (cnt == 0 && k < 64) begin
            step();
            k++;
            if (tick[ch] === 1'b1) cnt = k;
        end
    endtask

    // Edges until clk_out of channel ch reads 0; 0 on timeout.
    task automatic wait_fall(input logic [1:0] ch, output int cnt);
        int k;
        k   = 0;
        cnt = 0;
        while (cnt == 0 && k < 64) begin
            step();
            k++;
            if (clk_out[ch] === 1'b0) cnt = k;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        CLR   = 1'b1;
        wr_en = 1'b0;
        wr_ch = 2'd0;
        wr_tc = '0;
        en    = '0;

        // Reset state and default terminal count.
        step();
        step();
        chk("rst_clk_out", 32'(clk_out), 32'd0);
        chk("rst_tick",    32'(tick),    32'd0);
        chk("rst_pend",    32'(pend),    32'd0);
        chk("def_tc_defaults", calc_def_tc(100_000_000, 1), 32'd49_999_999);
        CLR = 1'b0;
        step();
        en = 3'b100;
        wait_rise(2'd2, n);
        chk("def_tc_first_rise", n, 32'd6);
        chk("def_tc_clk_high", 32'(clk_out[2]), 32'd1);
        en = 3'b000;
        step();
        chk("stop_clk_low", 32'(clk_out[2]), 32'd0);
        chk("stop_tick_low", 32'(tick[2]), 32'd0);

        // Idle write TC=2 to ch0, then run.
        write(2'd0, 8'd2);
        chk("idle_write_pend0", 32'(pend[0]), 32'd0);
        en = 3'b001;
        wait_rise(2'd0, n);
        chk("ch0_first_rise", n, 32'd3);
        chk("ch0_clk_high", 32'(clk_out[0]), 32'd1);
        wait_rise(2'd0, n);
        chk("ch0_period", n, 32'd6);
        wait_fall(2'd0, n);
        chk("ch0_high_half", n, 32'd3);

        // ch1 at TC=3, retargeted to TC=1 mid-half.
        write(2'd1, 8'd3);
        en = 3'b011;
        wait_rise(2'd1, n);
        chk("ch1_first_rise", n, 32'd4);
        step();
        write(2'd1, 8'd1);
        chk("ch1_pend_set", 32'(pend[1]), 32'd1);
        chk("ch1_still_high", 32'(clk_out[1]), 32'd1);
        wait_fall(2'd1, n);
        chk("ch1_rest_of_half", n, 32'd2);
        chk("ch1_pend_clear", 32'(pend[1]), 32'd0);
        wait_rise(2'd1, n);
        chk("ch1_new_low_half", n, 32'd2);
        wait_fall(2'd1, n);
        chk("ch1_new_high_half", n, 32'd2);

        // ch2 at TC=4, write TC=0 exactly in the wrap cycle.
        write(2'd2, 8'd4);
        en = 3'b111;
        wait_rise(2'd2, n);
        chk("ch2_tc4_rise", n, 32'd5);
        for (int i = 0; i < 4; i++) step();
        write(2'd2, 8'd0);
        chk("bypass_fall", 32'(clk_out[2]), 32'd0);
        chk("bypass_no_pend", 32'(pend[2]), 32'd0);
        step();
        chk("tc0_rise", 32'(clk_out[2]), 32'd1);
        chk("tc0_tick", 32'(tick[2]), 32'd1);
        chk("tc0_pend", 32'(pend[2]), 32'd0);
        step();
        chk("tc0_fall", 32'(clk_out[2]), 32'd0);
        chk("tc0_tick_low", 32'(tick[2]), 32'd0);

        // ch2 disabled with a pending write; re-enable uses the new TC.
        en = 3'b011;
        step();
        write(2'd2, 8'd2);
        en = 3'b111;
        wait_rise(2'd2, n);
        chk("ch2_tc2_rise", n, 32'd3);
        step();
        write(2'd2, 8'd1);
        chk("ch2_pend_set", 32'(pend[2]), 32'd1);
        en = 3'b011;
        step();
        chk("ch2_off_clk", 32'(clk_out[2]), 32'd0);
        chk("ch2_off_pend", 32'(pend[2]), 32'd0);
        en = 3'b111;
        wait_rise(2'd2, n);
        chk("ch2_new_tc_rise", n, 32'd2);

        // Write to a nonexistent channel changes nothing.
        en = 3'b101;
        step();
        write(2'd3, 8'd0);
        chk("bad_ch_pend", 32'(pend), 32'd0);
        en = 3'b111;
        wait_rise(2'd1, n);
        chk("bad_ch_ch1_tc", n, 32'd2);
        wait_rise(2'd0, n);
        wait_rise(2'd0, n);
        chk("bad_ch_ch0_period", n, 32'd6);

        // Asynchronous reset mid-run, then restart from the default TC.
        wait_rise(2'd0, n);
        #2;
        CLR = 1'b1;
        #1;
        chk("async_clr_clk", 32'(clk_out), 32'd0);
        chk("async_clr_tick", 32'(tick), 32'd0);
        chk("async_clr_pend", 32'(pend), 32'd0);
        step();
        chk("held_clr_clk", 32'(clk_out), 32'd0);
        CLR = 1'b0;
        wait_rise(2'd0, n);
        chk("post_clr_rise", n, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
